carbon_fabric_ram_slave: RTL and testbench

Fabric request/response endpoint backed by a DEPTH-word register-file memory; it terminates one fabric channel on the slave side, directly downstream of a fabric master or interconnect port. Reads and strobed writes complete in order with one-cycle minimum latency. A 2-entry response queue allows full throughput of one request per cycle under continuous `rsp_ready`, and absorbs response backpressure without dropping requests.

---
 rtl/carbon_fabric_ram_slave.sv | 149 ++++++++++++++
 tb/tb_carbon_fabric_ram_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carbon_fabric_ram_slave.sv
// Fabric slave endpoint over a DEPTH-word register-file memory with a 2-entry in-order response queue.
// Define CARBON_FABRIC_RAM_ERR_EN to enable range, opcode and size checking (DECODE_ERR / UNSUPPORTED).
package carbon_arch_pkg;
    localparam int CARBON_FABRIC_ATTR_WIDTH_BITS = 8;
endpackage

module carbon_fabric_ram_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int OP_W   = 8,
    parameter int SIZE_W = 3,
    parameter int ATTR_W = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [OP_W-1:0]     i_req_op,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [DATA_W-1:0]   i_req_wdata,
    input  logic [DATA_W/8-1:0] i_req_wstrb,
    input  logic [SIZE_W-1:0]   i_req_size,
    input  logic [ATTR_W-1:0]   i_req_attr,
    input  logic [ID_W-1:0]     i_req_id,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DATA_W-1:0]   o_rsp_rdata,
    output logic [CODE_W-1:0]   o_rsp_code,
    output logic [ID_W-1:0]     o_rsp_id
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [CODE_W-1:0] CODE_OK     = CODE_W'(0);
    localparam logic [CODE_W-1:0] CODE_DECODE = CODE_W'(1);
    localparam logic [CODE_W-1:0] CODE_UNSUP  = CODE_W'(2);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_head_rdata, r_tail_rdata;
    logic [CODE_W-1:0] r_head_code, r_tail_code;
    logic [ID_W-1:0]   r_head_id, r_tail_id;

    logic [IDX_W-1:0]  w_idx;
    logic              w_accept;
    logic              w_pop;
    logic              w_is_write;
    logic              w_err;
    logic [CODE_W-1:0] w_code;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused;

    assign w_idx = i_req_addr[OFF +: IDX_W];

`ifdef CARBON_FABRIC_RAM_ERR_EN
    localparam int IDXF_W = ADDR_W - OFF;
    localparam logic [IDXF_W-1:0] DEPTH_L = IDXF_W'(DEPTH);

    logic [IDXF_W-1:0] w_idx_full;
    assign w_idx_full = i_req_addr[ADDR_W-1:OFF];

    always_comb begin
        w_code = CODE_OK;
        if (w_idx_full >= DEPTH_L) begin
            w_code = CODE_DECODE;
        end else if ((i_req_op != OP_W'(0) && i_req_op != OP_W'(1)) ||
                     (i_req_size > SIZE_W'(OFF))) begin
            w_code = CODE_UNSUP;
        end
    end

    assign w_is_write = (i_req_op == OP_W'(1));
    assign w_unused   = ^{i_req_attr, i_req_addr};
`else
    // Index wraps modulo DEPTH; only op bit 0 matters and size is don't-care.
    assign w_code     = CODE_OK;
    assign w_is_write = i_req_op[0];
    assign w_unused   = ^{i_req_attr, i_req_addr, i_req_op, i_req_size};
`endif

    assign w_err       = (w_code != CODE_OK);
    assign o_req_ready = (r_count != 2'd2) && i_rst_n;
    assign o_rsp_valid = (r_count != 2'd0);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign w_rdata     = (w_is_write || w_err) ? '0 : r_mem[w_idx];

    always_ff @(posedge i_clk) begin
        if (w_accept && w_is_write && !w_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_req_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Head register drives the response outputs; tail only fills while the head is stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count      <= 2'd0;
            r_head_rdata <= '0;
            r_head_code  <= '0;
            r_head_id    <= '0;
            r_tail_rdata <= '0;
            r_tail_code  <= '0;
            r_tail_id    <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head_rdata <= w_rdata;
                        r_head_code  <= w_code;
                        r_head_id    <= i_req_id;
                    end else begin
                        r_tail_rdata <= w_rdata;
                        r_tail_code  <= w_code;
                        r_tail_id    <= i_req_id;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head_rdata <= r_tail_rdata;
                        r_head_code  <= r_tail_code;
                        r_head_id    <= r_tail_id;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    r_head_rdata <= w_rdata;
                    r_head_code  <= w_code;
                    r_head_id    <= i_req_id;
                end
                default: ;
            endcase
        end
    end

    assign o_rsp_rdata = r_head_rdata;
    assign o_rsp_code  = r_head_code;
    assign o_rsp_id    = r_head_id;

endmodule

// File: tb/tb_carbon_fabric_ram_slave.sv
// Randomized and directed bench for carbon_fabric_ram_slave against a queue/array reference model.
module tb_carbon_fabric_ram_slave;
    localparam int AW = carbon_arch_pkg::CARBON_FABRIC_ATTR_WIDTH_BITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_size = '0;
    logic [AW-1:0] req_attr = '0;
    logic [3:0]  req_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_code;
    logic [3:0]  rsp_id;

    always #5 clk = ~clk;

    carbon_fabric_ram_slave dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .i_req_wstrb(req_wstrb), .i_req_size(req_size), .i_req_attr(req_attr),
        .i_req_id(req_id),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_code(rsp_code), .o_rsp_id(rsp_id)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  code;
        logic [3:0]  id;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] pop_rdata[$];
    logic [7:0]  pop_code[$];
    logic [3:0]  pop_id[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_dut_acc = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour: word index = addr/4, byte-lane writes, reads return current word.
    function automatic rsp_t model_req(input logic [7:0] op, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       input logic [2:0] size, input logic [3:0] id);
        rsp_t r;
        int   widx;
        bit   wr;
        widx    = int'(addr / 4);
        r.id    = id;
        r.rdata = '0;
        r.code  = '0;
`ifdef CARBON_FABRIC_RAM_ERR_EN
        wr = (op == 8'd1);
        if (widx >= 256) r.code = 8'd1;
        else if (op > 8'd1 || size > 3'd2) r.code = 8'd2;
`else
        wr   = op[0];
        widx = widx % 256;
        if (size > 3'd7) r.code = 8'd0;
`endif
        if (r.code == 8'd0) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) ref_mem[widx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                r.rdata = ref_mem[widx];
            end
        end
        return r;
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic do_cycle(input logic v, input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] size, input logic [3:0] id, input logic rr);
        bit acc;
        req_valid = v; req_op = op; req_addr = addr; req_wdata = wdata;
        req_wstrb = strb; req_size = size; req_id = id; rsp_ready = rr;
        req_attr  = AW'($urandom);
        #1;
        check_val("req_ready", 32'(req_ready), 32'(exp_q.size() != 2));
        check_val("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val("rsp_rdata", rsp_rdata, exp_q[0].rdata);
            check_val("rsp_code", 32'(rsp_code), 32'(exp_q[0].code));
            check_val("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
        end
        if (v && req_ready) n_dut_acc++;
        acc = v && (exp_q.size() != 2);
        if (rr && exp_q.size() != 0) begin
            pop_rdata.push_back(rsp_rdata);
            pop_code.push_back(rsp_code);
            pop_id.push_back(rsp_id);
            void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back(model_req(op, addr, wdata, strb, size, id));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            do_cycle(1'b0, 8'd0, 32'd0, 32'd0, 4'd0, 3'd2, 4'd0, 1'b1);
        end
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_log();
        pop_rdata.delete();
        pop_code.delete();
        pop_id.delete();
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("rst_req_ready", 32'(req_ready), 32'd0);
            check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
            check_val("rst_rsp_code", 32'(rsp_code), 32'd0);
            check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
        end
        exp_q.delete();
        rst_n = 1'b1; req_valid = 1'b0;
        #1;
        check_val("req_ready_after_rst", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        apply_reset(3);

        for (int i = 0; i < 256; i++) begin
            do_cycle(1'b1, 8'd1, 32'(i * 4), $urandom, 4'hF, 3'd2, 4'(i), 1'b1);
        end
        drain();

        clear_log();
        do_cycle(1'b1, 8'd1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h10, 32'h0, 4'h3, 3'd2, 4'd5, 1'b1);
        do_cycle(1'b1, 8'd1, 32'h10, 32'h0000CAFE, 4'h3, 3'd2, 4'd6, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h10, 32'h0, 4'h0, 3'd2, 4'd7, 1'b1);
        drain();
        check_val("wr_rsp_rdata", pop_rdata[0], 32'h0);
        check_val("wr_rsp_code", 32'(pop_code[0]), 32'd0);
        check_val("wr_rsp_id", 32'(pop_id[0]), 32'd3);
        check_val("rd_rsp_rdata", pop_rdata[1], 32'hDEADBEEF);
        check_val("rd_rsp_id", 32'(pop_id[1]), 32'd5);
        check_val("readback", pop_rdata[3], 32'hDEADCAFE);

        clear_log();
        acc0 = n_dut_acc;
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 8'd0, 32'h20 + 32'(i * 4), 32'h0, 4'h0, 3'd2, 4'(8 + i), 1'b1);
        end
        check_val("b2b_accepts", 32'(n_dut_acc - acc0), 32'd4);
        drain();
        for (int i = 0; i < 4; i++) check_val("b2b_id", 32'(pop_id[i]), 32'(8 + i));

        clear_log();
        acc0 = n_dut_acc;
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1'b1, 8'd0, 32'(i * 4), 32'h0, 4'h0, 3'd2, 4'(i), 1'b0);
        end
        check_val("bp_accepts", 32'(n_dut_acc - acc0), 32'd2);
        do_cycle(1'b1, 8'd0, 32'h0C, 32'h0, 4'h0, 3'd2, 4'd3, 1'b1);
        check_val("bp_after_pop", 32'(n_dut_acc - acc0), 32'd2);
        do_cycle(1'b1, 8'd0, 32'h0C, 32'h0, 4'h0, 3'd2, 4'd3, 1'b1);
        check_val("bp_third_acc", 32'(n_dut_acc - acc0), 32'd3);
        drain();
        for (int i = 0; i < 3; i++) check_val("bp_order_id", 32'(pop_id[i]), 32'(i + 1));

        clear_log();
`ifdef CARBON_FABRIC_RAM_ERR_EN
        do_cycle(1'b1, 8'd1, 32'h24, 32'hA5A5A5A5, 4'hF, 3'd2, 4'd0, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h400, 32'h0, 4'h0, 3'd2, 4'd1, 1'b1);
        do_cycle(1'b1, 8'h07, 32'h20, 32'h0, 4'h0, 3'd2, 4'd2, 1'b1);
        do_cycle(1'b1, 8'd1, 32'h24, 32'h12345678, 4'hF, 3'd3, 4'd3, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h24, 32'h0, 4'h0, 3'd2, 4'd4, 1'b1);
        drain();
        check_val("decode_code", 32'(pop_code[1]), 32'd1);
        check_val("decode_rdata", pop_rdata[1], 32'd0);
        check_val("badop_code", 32'(pop_code[2]), 32'd2);
        check_val("badsize_code", 32'(pop_code[3]), 32'd2);
        check_val("badsize_mem", pop_rdata[4], 32'hA5A5A5A5);
`else
        do_cycle(1'b1, 8'd1, 32'h400, 32'h13579BDF, 4'hF, 3'd2, 4'd1, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h0, 32'h0, 4'h0, 3'd2, 4'd2, 1'b1);
        drain();
        check_val("alias_rdata", pop_rdata[1], 32'h13579BDF);
        check_val("alias_code", 32'(pop_code[1]), 32'd0);
`endif

        clear_log();
        do_cycle(1'b1, 8'd1, 32'h40, 32'h11223344, 4'hF, 3'd2, 4'd1, 1'b0);
        do_cycle(1'b1, 8'd1, 32'h44, 32'h55667788, 4'hF, 3'd2, 4'd2, 1'b0);
        do_cycle(1'b0, 8'd0, 32'h0, 32'h0, 4'h0, 3'd2, 4'd0, 1'b0);
        apply_reset(2);
        do_cycle(1'b1, 8'd0, 32'h40, 32'h0, 4'h0, 3'd2, 4'd3, 1'b1);
        do_cycle(1'b1, 8'd0, 32'h44, 32'h0, 4'h0, 3'd2, 4'd4, 1'b1);
        drain();
        check_val("rst_keep_w0", pop_rdata[0], 32'h11223344);
        check_val("rst_keep_w1", pop_rdata[1], 32'h55667788);

        for (int n = 0; n < 600; n++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            op   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                               : 32'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
            do_cycle($urandom_range(0, 3) != 0, op, addr, $urandom, 4'($urandom),
                     3'($urandom_range(0, 3)), 4'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
